// File: rtl/fp_div_pkg.sv
// ---------------------------------------------------------------------------
// fp_div_pkg
// Shared definitions for the single-precision FP units: FSM state encoding
// of the divider and the IEEE-754 binary32 constants used when unpacking,
// resolving special operands and packing results.
// ---------------------------------------------------------------------------
package fp_div_pkg;

  typedef enum logic [3:0] {
    IDLE,
    UNPACK,
    SPECIAL,
    NORM_A,
    NORM_B,
    DIV_0,
    DIV_1,
    DIV_2,
    NORM_1,
    NORM_2,
    ROUND,
    PACK
  } fp_div_state_e;

  // Canonical quiet NaN returned for every invalid operation.
  localparam logic [31:0]        QNAN     = 32'hFFC0_0000;
  // Unbiased exponents are carried as 10-bit two's complement values.
  localparam logic signed [9:0]  EXP_BIAS = 10'sd127;
  localparam logic signed [9:0]  EMIN     = -10'sd126;
  localparam logic signed [9:0]  EMAX     = 10'sd127;
  // Unbiased value of an all-ones exponent field (inf/NaN).
  localparam logic signed [9:0]  E_INF    = 10'sd128;
  // Unbiased value of an all-zeros exponent field (zero/denormal).
  localparam logic signed [9:0]  E_DENORM = -10'sd127;
  // Index of the last DIV_1 iteration counter value (51 iterations: 50..0).
  localparam logic [5:0]         DIV_ITER = 6'd50;

endpackage

// File: rtl/fp_div.sv
// ---------------------------------------------------------------------------
// fp_div
// Multi-cycle IEEE-754 single-precision divider (res = op_a / op_b) using
// restoring division, round-to-nearest-even, denormal support.
//
// Ports:
//   clk    in   1   clock, all state updates on the rising edge
//   rst    in   1   synchronous active-high reset
//   start  in   1   operand strobe, only honoured while done=1
//   op_a   in  32   dividend (binary32)
//   op_b   in  32   divisor  (binary32)
//   done   out  1   high while idle; also the ready indication
//   res    out 32   quotient, held until the next result is packed
// ---------------------------------------------------------------------------
module fp_div
  import fp_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        done,
  output logic [31:0] res
);

  fp_div_state_e     state_q, state_d;
  logic [31:0]       op_a_q, op_a_d, op_b_q, op_b_d;
  logic [23:0]       a_m_q, a_m_d, b_m_q, b_m_d;
  logic signed [9:0] a_e_q, a_e_d, b_e_q, b_e_d;
  logic              a_s_q, a_s_d, b_s_q, b_s_d;
  logic [23:0]       z_m_q, z_m_d;
  logic signed [9:0] z_e_q, z_e_d;
  logic              z_s_q, z_s_d;
  logic              guard_q, guard_d, round_q, round_d, sticky_q, sticky_d;
  logic [50:0]       quot_q, quot_d;
  logic [23:0]       rem_q, rem_d;
  logic [50:0]       dvd_q, dvd_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [31:0]       res_q, res_d;

  logic [24:0]       rem_trial;
  logic signed [9:0] e_norm;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, z_sign;

  // Operand classification from the unpacked fields (valid from SPECIAL on).
  assign a_nan  = (a_e_q == E_INF) && (a_m_q != 24'd0);
  assign b_nan  = (b_e_q == E_INF) && (b_m_q != 24'd0);
  assign a_inf  = (a_e_q == E_INF) && (a_m_q == 24'd0);
  assign b_inf  = (b_e_q == E_INF) && (b_m_q == 24'd0);
  assign a_zero = (a_e_q == E_DENORM) && (a_m_q == 24'd0);
  assign b_zero = (b_e_q == E_DENORM) && (b_m_q == 24'd0);
  assign z_sign = a_s_q ^ b_s_q;

  assign done = (state_q == IDLE);
  assign res  = res_q;

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    a_m_d    = a_m_q;
    b_m_d    = b_m_q;
    a_e_d    = a_e_q;
    b_e_d    = b_e_q;
    a_s_d    = a_s_q;
    b_s_d    = b_s_q;
    z_m_d    = z_m_q;
    z_e_d    = z_e_q;
    z_s_d    = z_s_q;
    guard_d  = guard_q;
    round_d  = round_q;
    sticky_d = sticky_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    // Partial remainder with the next dividend bit brought in.
    rem_trial = {rem_q, dvd_q[50]};
    e_norm    = z_e_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_a_d  = op_a;
          op_b_d  = op_b;
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        a_m_d   = {1'b0, op_a_q[22:0]};
        b_m_d   = {1'b0, op_b_q[22:0]};
        a_e_d   = $signed({2'b00, op_a_q[30:23]}) - EXP_BIAS;
        b_e_d   = $signed({2'b00, op_b_q[30:23]}) - EXP_BIAS;
        a_s_d   = op_a_q[31];
        b_s_d   = op_b_q[31];
        state_d = SPECIAL;
      end

      SPECIAL: begin
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
          res_d   = QNAN;
          state_d = IDLE;
        end else if (a_inf || b_zero) begin
          res_d   = {z_sign, 8'hFF, 23'd0};
          state_d = IDLE;
        end else if (b_inf || a_zero) begin
          res_d   = {z_sign, 31'd0};
          state_d = IDLE;
        end else begin
          // Denormals keep the minimum exponent and get normalised below;
          // normals just gain their hidden bit and skip normalisation.
          if (a_e_q == E_DENORM) a_e_d = EMIN;
          else                   a_m_d[23] = 1'b1;
          if (b_e_q == E_DENORM) b_e_d = EMIN;
          else                   b_m_d[23] = 1'b1;
          if (a_e_q == E_DENORM)      state_d = NORM_A;
          else if (b_e_q == E_DENORM) state_d = NORM_B;
          else                        state_d = DIV_0;
        end
      end

      NORM_A: begin
        if (a_m_q[23]) begin
          state_d = b_m_q[23] ? DIV_0 : NORM_B;
        end else begin
          a_m_d = {a_m_q[22:0], 1'b0};
          a_e_d = a_e_q - 10'sd1;
        end
      end

      NORM_B: begin
        if (b_m_q[23]) begin
          state_d = DIV_0;
        end else begin
          b_m_d = {b_m_q[22:0], 1'b0};
          b_e_d = b_e_q - 10'sd1;
        end
      end

      DIV_0: begin
        z_s_d  = z_sign;
        z_e_d  = a_e_q - b_e_q;
        quot_d = 51'd0;
        // The dividend is {a_m, 50'b0}. Its top 23 bits can never reach the
        // (normalised) divisor, so those quotient bits are zero and the
        // remainder after them is simply a_m[23:1]; start from there and
        // feed the remaining 51 dividend bits, one per DIV_1 cycle.
        rem_d  = {1'b0, a_m_q[23:1]};
        dvd_d  = {a_m_q[0], 50'd0};
        cnt_d  = DIV_ITER;
        state_d = DIV_1;
      end

      DIV_1: begin
        if (rem_trial >= {1'b0, b_m_q}) begin
          rem_d  = 24'(rem_trial - {1'b0, b_m_q});
          quot_d = {quot_q[49:0], 1'b1};
        end else begin
          rem_d  = rem_trial[23:0];
          quot_d = {quot_q[49:0], 1'b0};
        end
        dvd_d = {dvd_q[49:0], 1'b0};
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd0) state_d = DIV_2;
      end

      DIV_2: begin
        z_m_d    = quot_q[50:27];
        guard_d  = quot_q[26];
        round_d  = quot_q[25];
        sticky_d = (|quot_q[24:0]) | (rem_q != 24'd0);
        state_d  = NORM_1;
      end

      NORM_1: begin
        // Quotient of two normalised mantissas lies in (0.5, 2): at most one
        // left shift is ever needed.
        if (!z_m_q[23]) begin
          z_m_d   = {z_m_q[22:0], guard_q};
          guard_d = round_q;
          round_d = 1'b0;
          e_norm  = z_e_q - 10'sd1;
        end
        z_e_d   = e_norm;
        state_d = (e_norm < EMIN) ? NORM_2 : ROUND;
      end

      NORM_2: begin
        if (z_e_q < EMIN) begin
          z_e_d    = z_e_q + 10'sd1;
          z_m_d    = {1'b0, z_m_q[23:1]};
          guard_d  = z_m_q[0];
          round_d  = guard_q;
          sticky_d = sticky_q | round_q;
          // Leave as soon as this shift brings the exponent up to EMIN.
          state_d  = (z_e_q + 10'sd1 < EMIN) ? NORM_2 : ROUND;
        end else begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
          z_m_d = z_m_q + 24'd1;
          if (z_m_q == 24'hFF_FFFF) z_e_d = z_e_q + 10'sd1;
        end
        state_d = PACK;
      end

      PACK: begin
        if (z_e_q > EMAX) begin
          res_d = {z_s_q, 8'hFF, 23'd0};
        end else if ((z_e_q == EMIN) && !z_m_q[23]) begin
          res_d = {z_s_q, 8'h00, z_m_q[22:0]};
        end else begin
          res_d = {z_s_q, z_e_q[7:0] + EXP_BIAS[7:0], z_m_q[22:0]};
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      a_m_q    <= '0;
      b_m_q    <= '0;
      a_e_q    <= '0;
      b_e_q    <= '0;
      a_s_q    <= 1'b0;
      b_s_q    <= 1'b0;
      z_m_q    <= '0;
      z_e_q    <= '0;
      z_s_q    <= 1'b0;
      guard_q  <= 1'b0;
      round_q  <= 1'b0;
      sticky_q <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      a_m_q    <= a_m_d;
      b_m_q    <= b_m_d;
      a_e_q    <= a_e_d;
      b_e_q    <= b_e_d;
      a_s_q    <= a_s_d;
      b_s_q    <= b_s_d;
      z_m_q    <= z_m_d;
      z_e_q    <= z_e_d;
      z_s_q    <= z_s_d;
      guard_q  <= guard_d;
      round_q  <= round_d;
      sticky_q <= sticky_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// ---------------------------------------------------------------------------
// tb_fp_div
// Directed bench for fp_div: a table of operand pairs with hand-computed
// quotients and latencies, followed by reset and back-to-back sequences.
// ---------------------------------------------------------------------------
module tb_fp_div;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  localparam int NVEC  = 14;
  localparam int LIMIT = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        done;
  logic [31:0] res;

  int total = 0;
  int bad   = 0;
  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  fp_div dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .done  (done),
    .res   (res)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, want);
    end
  endtask

  task automatic check_int(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // Called at a negedge just after the accepting edge; counts rising edges
  // until done is seen high (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check_int("done_timeout", lat, -1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    r = res;
  endtask

  initial begin
    logic [31:0] r;
    int          lat;

    vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 58}; // 6/2
    vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 58}; // 1/3
    vecs[2]  = '{32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 58}; // -6/2
    vecs[3]  = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 2};  // 1/0
    vecs[4]  = '{32'h0000_0000, 32'h0000_0000, 32'hFFC0_0000, 2};  // 0/0
    vecs[5]  = '{32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000, 2};  // -1/inf
    vecs[6]  = '{32'h7F80_0000, 32'h7F80_0000, 32'hFFC0_0000, 2};  // inf/inf
    vecs[7]  = '{32'h7FC0_0000, 32'h3F80_0000, 32'hFFC0_0000, 2};  // NaN/1
    vecs[8]  = '{32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 2};  // inf/2
    vecs[9]  = '{32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 2};  // 0/5
    vecs[10] = '{32'h3F80_0000, 32'h8000_0000, 32'hFF80_0000, 2};  // 1/-0
    vecs[11] = '{32'h0080_0000, 32'h4000_0000, 32'h0040_0000, 59}; // denormal out
    vecs[12] = '{32'h0040_0000, 32'h0080_0000, 32'h3F00_0000, 60}; // denormal in
    vecs[13] = '{32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, 58}; // overflow

    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_int("reset_done", int'(done), 1);
    check32("reset_res", res, 32'h0);
    $display("reset: done=%0b res=%08h", done, res);

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].a, vecs[i].b, r, lat);
      $display("vec %0d: %08h / %08h -> %08h (want %08h) lat=%0d (want %0d)",
               i, vecs[i].a, vecs[i].b, r, vecs[i].exp_res, lat, vecs[i].exp_lat);
      check32($sformatf("vec%0d_res", i), r, vecs[i].exp_res);
      check_int($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
    end

    // Reset in DIV_1 cycle 20: nothing partial may reach res.
    run_op(32'h3F80_0000, 32'h4040_0000, r, lat);
    op_a  = 32'h40C0_0000;
    op_b  = 32'h4000_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
    check_int("mid_busy", int'(done), 0);
    check32("mid_res_held", res, 32'h3EAA_AAAB);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("reset mid-div: done=%0b res=%08h", done, res);
    check_int("mid_rst_done", int'(done), 1);
    check32("mid_rst_res", res, 32'h0);
    run_op(32'h40C0_0000, 32'h4000_0000, r, lat);
    $display("after reset: 40c00000 / 40000000 -> %08h lat=%0d", r, lat);
    check32("post_rst_res", r, 32'h4040_0000);

    // Reset and start together: reset wins, nothing is latched.
    op_a  = 32'h3F80_0000;
    op_b  = 32'h0000_0000;
    start = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    $display("rst+start: done=%0b res=%08h", done, res);
    check_int("rst_start_done", int'(done), 1);
    check32("rst_start_res", res, 32'h0);

    // Back-to-back with start held high.
    op_a  = 32'h40C0_0000;
    op_b  = 32'h4000_0000;
    start = 1'b1;
    @(negedge clk);
    check_int("b2b_accept0", int'(done), 0);
    op_a = 32'h3F80_0000;
    op_b = 32'h4040_0000;
    wait_done(lat);
    $display("b2b 0: res=%08h lat=%0d", res, lat);
    check32("b2b_res0", res, 32'h4040_0000);
    check_int("b2b_lat0", lat, 58);
    @(negedge clk);
    check_int("b2b_accept1", int'(done), 0);
    op_a = 32'hBF80_0000;
    op_b = 32'h7F80_0000;
    wait_done(lat);
    $display("b2b 1: res=%08h lat=%0d", res, lat);
    check32("b2b_res1", res, 32'h3EAA_AAAB);
    check_int("b2b_lat1", lat, 58);
    @(negedge clk);
    check_int("b2b_accept2", int'(done), 0);
    start = 1'b0;
    wait_done(lat);
    $display("b2b 2: res=%08h lat=%0d", res, lat);
    check32("b2b_res2", res, 32'h8000_0000);
    check_int("b2b_lat2", lat, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
